// File: rtl/seq_alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
package seq_alu_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int SEL_W_DEF  = 6;

  typedef enum logic [SEL_W_DEF-1:0] {
    OP_AND  = 6'd0,
    OP_OR   = 6'd1,
    OP_XOR  = 6'd2,
    OP_ADD  = 6'd3,
    OP_SUB  = 6'd4,
    OP_SLT  = 6'd5,
    OP_SLTU = 6'd6,
    OP_SLL  = 6'd7,
    OP_SRL  = 6'd8,
    OP_SRA  = 6'd9,
    OP_MUL  = 6'd10,
    OP_DIVU = 6'd11,
    OP_REMU = 6'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;
endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// result is the combinational outcome of the final iteration, valid while done=1.
module muldiv_iter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_div,
  input  logic              is_rem,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  // r_acc: product accumulator or partial remainder
  // r_x:   shifted multiplicand or dividend/quotient
  // r_y:   multiplier (shifted out) or divisor
  logic             r_busy, r_is_div, r_is_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_acc, r_x, r_y;
  logic [DATA_W-1:0] w_acc_nxt, w_x_nxt, w_y_nxt;
  logic [DATA_W:0]   w_shift, w_diff;

  assign w_shift = {r_acc, r_x[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_y};

  always_comb begin
    w_acc_nxt = r_acc;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (r_is_div) begin
      if (!w_diff[DATA_W]) begin
        w_acc_nxt = w_diff[DATA_W-1:0];
        w_x_nxt   = {r_x[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shift[DATA_W-1:0];
        w_x_nxt   = {r_x[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = r_y[0] ? (r_acc + r_x) : r_acc;
      w_x_nxt   = r_x << 1;
      w_y_nxt   = r_y >> 1;
    end
  end

  assign done   = r_busy && (r_cnt == CNT_W'(DATA_W - 1));
  assign result = (r_is_div && !r_is_rem) ? w_x_nxt : w_acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_is_rem <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_is_div <= is_div;
      r_is_rem <= is_rem;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= a;
      r_y      <= b;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MUL/DIVU/REMU,
// valid/ready on both sides with one operation in flight.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_illegal
);
  state_e              r_state, w_next;
  logic [DATA_W-1:0]   r_result, w_short_res, w_md_result;
  logic                r_illegal, w_illegal, w_long;
  logic                w_accept, w_md_start, w_md_done;
  logic                w_is_div, w_is_rem, w_b_zero;
  logic [SHAMT_W-1:0]  w_shamt;

  assign w_shamt  = in_b[SHAMT_W-1:0];
  assign w_b_zero = (in_b == '0);
  assign w_is_div = (in_op == SEL_W'(OP_DIVU)) || (in_op == SEL_W'(OP_REMU));
  assign w_is_rem = (in_op == SEL_W'(OP_REMU));

  // Single-cycle results; divide-by-zero is resolved here so it skips the iterator.
  always_comb begin
    w_short_res = '0;
    w_illegal   = 1'b0;
    w_long      = 1'b0;
    case (in_op)
      SEL_W'(OP_AND):  w_short_res = in_a & in_b;
      SEL_W'(OP_OR):   w_short_res = in_a | in_b;
      SEL_W'(OP_XOR):  w_short_res = in_a ^ in_b;
      SEL_W'(OP_ADD):  w_short_res = in_a + in_b;
      SEL_W'(OP_SUB):  w_short_res = in_a - in_b;
      SEL_W'(OP_SLT):  w_short_res = DATA_W'($signed(in_a) < $signed(in_b));
      SEL_W'(OP_SLTU): w_short_res = DATA_W'(in_a < in_b);
      SEL_W'(OP_SLL):  w_short_res = in_a << w_shamt;
      SEL_W'(OP_SRL):  w_short_res = in_a >> w_shamt;
      SEL_W'(OP_SRA):  w_short_res = $unsigned($signed(in_a) >>> w_shamt);
      SEL_W'(OP_MUL):  w_long = 1'b1;
      SEL_W'(OP_DIVU): begin
        if (w_b_zero) w_short_res = '1;
        else          w_long      = 1'b1;
      end
      SEL_W'(OP_REMU): begin
        if (w_b_zero) w_short_res = in_a;
        else          w_long      = 1'b1;
      end
      default:         w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    w_accept   = 1'b0;
    w_md_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          if (w_long) begin
            w_md_start = 1'b1;
            w_next     = ST_CALC;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_CALC: if (w_md_done) w_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (w_md_start),
    .is_div (w_is_div),
    .is_rem (w_is_rem),
    .a      (in_a),
    .b      (in_b),
    .done   (w_md_done),
    .result (w_md_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_long) begin
      r_result  <= w_short_res;
      r_illegal <= w_illegal;
    end else if ((r_state == ST_CALC) && w_md_done) begin
      r_result  <= w_md_result;
      r_illegal <= 1'b0;
    end
  end

  assign out_result  = r_result;
  assign out_zero    = (r_result == '0);
  assign out_illegal = r_illegal;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at DATA_W=64 and DATA_W=32: directed literal cases plus
// randomized traffic scored against a queue-based behavioural model.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  in_op = '0;
  logic [63:0] in_a = '0, in_b = '0;
  logic [1:0]  vld = '0, ordy = 2'b11;
  logic [1:0]  irdy, ovld, ozero, oill;
  logic [63:0] ores64;
  logic [31:0] ores32;
  int tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.DATA_W(64), .SEL_W(6)) dut64 (
    .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(irdy[0]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(ovld[0]), .out_ready(ordy[0]),
    .out_result(ores64), .out_zero(ozero[0]), .out_illegal(oill[0]));

  seq_alu #(.DATA_W(32), .SEL_W(6)) dut32 (
    .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(irdy[1]), .in_op(in_op),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .out_valid(ovld[1]), .out_ready(ordy[1]),
    .out_result(ores32), .out_zero(ozero[1]), .out_illegal(oill[1]));

  typedef struct { logic [63:0] res; bit ill; int due; } exp_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference behaviour straight from the opcode definitions, width w.
  function automatic void model(input int w, input logic [5:0] op, input logic [63:0] ai,
                                input logic [63:0] bi, output logic [63:0] r,
                                output bit ill, output bit lng);
    logic [63:0] m, a, b;
    longint sa, sb;
    int sh;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = ai & m;
    b  = bi & m;
    sh = int'(b[5:0]) & (w - 1);
    sa = (w == 64) ? longint'(a) : longint'({{32{a[31]}}, a[31:0]});
    sb = (w == 64) ? longint'(b) : longint'({{32{b[31]}}, b[31:0]});
    r = '0; ill = 0; lng = 0;
    case (op)
      6'd0:  r = a & b;
      6'd1:  r = a | b;
      6'd2:  r = a ^ b;
      6'd3:  r = a + b;
      6'd4:  r = a - b;
      6'd5:  r = (sa < sb) ? 64'd1 : 64'd0;
      6'd6:  r = (a < b) ? 64'd1 : 64'd0;
      6'd7:  r = a << sh;
      6'd8:  r = a >> sh;
      6'd9:  r = 64'(sa >>> sh);
      6'd10: begin r = a * b; lng = 1; end
      6'd11: if (b == 0) r = m; else begin r = a / b; lng = 1; end
      6'd12: if (b == 0) r = a; else begin r = a % b; lng = 1; end
      default: ill = 1;
    endcase
    r = r & m;
  endfunction

  // Per-width scoreboard: busy iff an accepted op has not been handed off.
  for (genvar g = 0; g < 2; g++) begin : g_cmp
    localparam int W = (g == 0) ? 64 : 32;
    exp_t q[$];
    always @(negedge clk) begin
      logic [63:0] r, got;
      bit ill, lng, was_empty, exp_v;
      if (reset) begin
        q.delete();
      end else begin
        was_empty = (q.size() == 0);
        exp_v = 0;
        if (!was_empty) exp_v = (cyc >= q[0].due);
        got = (g == 0) ? ores64 : {32'b0, ores32};
        chk($sformatf("w%0d in_ready", W), 64'(irdy[g]), 64'(was_empty));
        chk($sformatf("w%0d out_valid", W), 64'(ovld[g]), 64'(exp_v));
        if (ovld[g] && exp_v) begin
          chk($sformatf("w%0d result", W), got, q[0].res);
          chk($sformatf("w%0d zero", W), 64'(ozero[g]), 64'(q[0].res == 0));
          chk($sformatf("w%0d illegal", W), 64'(oill[g]), 64'(q[0].ill));
          if (ordy[g]) void'(q.pop_front());
        end
        if (vld[g] && was_empty) begin
          model(W, in_op, in_a, in_b, r, ill, lng);
          q.push_back('{r, ill, cyc + (lng ? W + 1 : 1)});
        end
      end
    end
  end

  task automatic issue(input int d, input logic [5:0] op, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output logic ill,
                       output logic z, output int lat);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!irdy[d] && n < 300) begin @(posedge clk); #1; n++; end
    in_op = op; in_a = a; in_b = b; vld[d] = 1'b1;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    lat = 1;
    while (!ovld[d] && lat < 300) begin @(posedge clk); #1; lat++; end
    res = (d == 0) ? ores64 : {32'b0, ores32};
    ill = oill[d];
    z   = ozero[d];
  endtask

  task automatic t(input int d, input string nm, input logic [5:0] op, input logic [63:0] a,
                   input logic [63:0] b, input logic [63:0] exp_res, input bit exp_ill,
                   input int exp_lat);
    logic [63:0] res;
    logic ill, z;
    int lat;
    issue(d, op, a, b, res, ill, z, lat);
    chk({nm, " result"}, res, exp_res);
    chk({nm, " zero"}, 64'(z), 64'(exp_res == 0));
    chk({nm, " illegal"}, 64'(ill), 64'(exp_ill));
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] res;
    logic ill, z;
    int lat;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset in_ready", 64'(irdy[d]), 64'd1);
      chk("reset out_valid", 64'(ovld[d]), 64'd0);
      chk("reset out_zero", 64'(ozero[d]), 64'd1);
      chk("reset out_illegal", 64'(oill[d]), 64'd0);
    end
    chk("reset out_result", ores64, 64'd0);

    // 64-bit directed cases
    t(0, "add wrap", 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1);
    t(0, "sub", 6'd4, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
    t(0, "sra", 6'd9, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 0, 1);
    t(0, "slt", 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0, 1);
    t(0, "sltu", 6'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1);
    t(0, "mul", 6'd10, 64'h1234, 64'h10, 64'h12340, 0, 65);
    t(0, "divu", 6'd11, 64'd100, 64'd7, 64'd14, 0, 65);
    t(0, "remu", 6'd12, 64'd100, 64'd7, 64'd2, 0, 65);
    t(0, "divu by 0", 6'd11, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    t(0, "remu by 0", 6'd12, 64'd5, 64'd0, 64'd5, 0, 1);
    t(0, "illegal op", 6'h3F, 64'd9, 64'd9, 64'd0, 1, 1);

    // 32-bit directed cases
    t(1, "w32 add wrap", 6'd3, 64'hFFFF_FFFF, 64'd1, 64'd0, 0, 1);
    t(1, "w32 sub", 6'd4, 64'd5, 64'd7, 64'hFFFF_FFFE, 0, 1);
    t(1, "w32 sra", 6'd9, 64'h8000_0000, 64'h23, 64'hF000_0000, 0, 1);
    t(1, "w32 slt", 6'd5, 64'hFFFF_FFFF, 64'd1, 64'd1, 0, 1);
    t(1, "w32 mul", 6'd10, 64'h1234, 64'h10, 64'h12340, 0, 33);
    t(1, "w32 divu", 6'd11, 64'd100, 64'd7, 64'd14, 0, 33);
    t(1, "w32 remu", 6'd12, 64'd100, 64'd7, 64'd2, 0, 33);

    // Backpressure: hold DONE for 10 cycles while offering a new op
    ordy[0] = 1'b0;
    issue(0, 6'd3, 64'd10, 64'd20, res, ill, z, lat);
    chk("bp first result", res, 64'd30);
    repeat (10) begin
      in_op = 6'd4; in_a = 64'd99; in_b = 64'd1; vld[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp in_ready", 64'(irdy[0]), 64'd0);
      chk("bp out_valid", 64'(ovld[0]), 64'd1);
      chk("bp hold result", ores64, 64'd30);
    end
    vld[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 64'(ovld[0]), 64'd0);
    chk("bp release in_ready", 64'(irdy[0]), 64'd1);

    // Reset during MUL around iteration 20
    @(posedge clk); #1;
    in_op = 6'd10; in_a = 64'h1234; in_b = 64'h10; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid-reset in_ready", 64'(irdy[0]), 64'd1);
    chk("mid-reset out_valid", 64'(ovld[0]), 64'd0);
    chk("mid-reset result", ores64, 64'd0);
    t(0, "add after reset", 6'd3, 64'd2, 64'd3, 64'd5, 0, 1);

    // Randomized traffic on both widths, scored by the model above
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      vld     = 2'($urandom_range(0, 3));
      ordy[0] = ($urandom_range(0, 3) != 0);
      ordy[1] = ($urandom_range(0, 3) != 0);
      in_op   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(13, 63))
                                            : 6'($urandom_range(0, 12));
      in_a    = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 1000))
                                            : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       in_b = 64'd0;
        1:       in_b = 64'($urandom_range(1, 70));
        default: in_b = {$urandom, $urandom};
      endcase
    end
    @(posedge clk); #1;
    vld = '0; ordy = 2'b11;
    repeat (80) @(posedge clk);
    #1;
    chk("drain in_ready w64", 64'(irdy[0]), 64'd1);
    chk("drain in_ready w32", 64'(irdy[1]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
